// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports. Data is
// favoured, but only for a bounded streak of grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_IF,
    SERVE_DM,
    RESP_IF,
    RESP_DM
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm, grant_if;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Data wins a contested IDLE cycle until it has taken MAX_DM_STREAK grants in a row.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;

    case (state_q)
      IDLE: begin
        grant_dm = dm_req_i && (!if_req_i || (streak_q < STREAK_MAX));
        grant_if = if_req_i && !grant_dm;
        if (grant_dm) begin
          state_d     = SERVE_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else if (grant_if) begin
          state_d     = SERVE_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      SERVE_IF: begin
        if (mem_ack_i) begin
          state_d    = RESP_IF;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata_i;
        end
      end
      SERVE_DM: begin
        if (mem_ack_i) begin
          state_d   = RESP_DM;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      RESP_IF, RESP_DM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_ack_o    = (state_q == RESP_IF);
  assign dm_ack_o    = (state_q == RESP_DM);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of the arbitration rules, compared on every cycle.
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int memWait = 0;

  // Model: the transaction in flight, whether its response cycle is due, and the data streak.
  logic        mBusy = 1'b0;
  logic        mRespond = 1'b0;
  logic        mIsData = 1'b0;
  logic        mWrite = 1'b0;
  logic [31:0] mAddr = '0;
  logic [31:0] mWdata = '0;
  logic [31:0] mIfData = '0;
  logic [31:0] mDmData = '0;
  int          mStreak = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAX_STREAK)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT samples on that edge.
  task automatic modelEdge();
    if (rst_i) begin
      mBusy = 0; mRespond = 0; mIsData = 0; mWrite = 0;
      mAddr = '0; mWdata = '0; mIfData = '0; mDmData = '0; mStreak = 0;
    end else if (mRespond) begin
      mRespond = 0;
    end else if (mBusy) begin
      if (mem_ack_i) begin
        mBusy = 0;
        mRespond = 1;
        if (!mIsData) mIfData = mem_rdata_i;
        else if (!mWrite) mDmData = mem_rdata_i;
      end
    end else if (dm_req_i && !(if_req_i && mStreak >= MAX_STREAK)) begin
      mBusy = 1; mIsData = 1; mWrite = dm_we_i; mAddr = dm_addr_i; mWdata = dm_wdata_i;
      mStreak = if_req_i ? ((mStreak + 1 > MAX_STREAK) ? MAX_STREAK : mStreak + 1) : 0;
    end else if (if_req_i) begin
      mBusy = 1; mIsData = 0; mWrite = 0; mAddr = if_addr_i; mWdata = '0;
      mStreak = 0;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    modelEdge();
    #1;
    cycle++;
    checkOutput("mem_req", 32'(mem_req_o), 32'(mBusy));
    checkOutput("mem_we", 32'(mem_we_o), 32'(mBusy & mWrite));
    checkOutput("mem_addr", mem_addr_o, mAddr);
    checkOutput("mem_wdata", mem_wdata_o, mWdata);
    checkOutput("if_ack", 32'(if_ack_o), 32'(mRespond & !mIsData));
    checkOutput("dm_ack", 32'(dm_ack_o), 32'(mRespond & mIsData));
    checkOutput("if_rdata", if_rdata_o, mIfData);
    checkOutput("dm_rdata", dm_rdata_o, mDmData);
  endtask

  // Memory answers each request after 1..maxLat cycles and throws in spurious acks when idle.
  task automatic applyStimulus(input int maxLat, input bit randomReq);
    mem_rdata_i = $urandom;
    if (rst_i) memWait = 0;
    if (mem_req_o) begin
      if (memWait == 0) memWait = $urandom_range(maxLat, 1);
      memWait--;
      mem_ack_i = (memWait == 0);
    end else begin
      mem_ack_i = ($urandom_range(7, 0) == 0);
    end
    if (randomReq) begin
      if (if_ack_o || (!if_req_i && $urandom_range(2, 0) == 0)) begin
        if_req_i = if_ack_o ? 1'($urandom_range(1, 0)) : 1'b1;
        if_addr_i = $urandom;
      end
      if (dm_ack_o || (!dm_req_i && $urandom_range(2, 0) == 0)) begin
        dm_req_i = dm_ack_o ? 1'($urandom_range(1, 0)) : 1'b1;
        dm_we_i = 1'($urandom_range(1, 0));
        dm_addr_i = $urandom;
        dm_wdata_i = $urandom;
      end
    end
  endtask

  initial begin
    logic [5:0] order;
    int grants;
    logic prevReq;

    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    checkOutput("reset_mem_req", 32'(mem_req_o), 32'h0);
    checkOutput("reset_acks", {30'b0, if_ack_o, dm_ack_o}, 32'h0);
    checkOutput("reset_rdata", if_rdata_o | dm_rdata_o, 32'h0);
    step();

    // Single fetch with a one-cycle memory.
    if_req_i = 1; if_addr_i = 32'h100;
    step();
    checkOutput("t1_req", 32'(mem_req_o), 32'h1);
    checkOutput("t1_addr", mem_addr_o, 32'h100);
    checkOutput("t1_we", 32'(mem_we_o), 32'h0);
    mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
    step();
    checkOutput("t1_ack", 32'(if_ack_o), 32'h1);
    checkOutput("t1_rdata", if_rdata_o, 32'hDEADBEEF);
    checkOutput("t1_req_low", 32'(mem_req_o), 32'h0);
    if_req_i = 0; mem_ack_i = 0;
    step();
    checkOutput("t1_ack_pulse", 32'(if_ack_o), 32'h0);
    checkOutput("t1_rdata_held", if_rdata_o, 32'hDEADBEEF);

    // Data write, memory latency 3.
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h1000; dm_wdata_i = 32'h12345678;
    step();
    checkOutput("t2_we_c1", 32'(mem_we_o), 32'h1);
    checkOutput("t2_wdata", mem_wdata_o, 32'h12345678);
    step();
    checkOutput("t2_we_c2", 32'(mem_we_o), 32'h1);
    step();
    checkOutput("t2_we_c3", 32'(mem_we_o), 32'h1);
    mem_ack_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    step();
    checkOutput("t2_ack", 32'(dm_ack_o), 32'h1);
    checkOutput("t2_rdata_kept", dm_rdata_o, 32'h0);
    checkOutput("t2_we_low", 32'(mem_we_o), 32'h0);
    dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
    step();

    // Simultaneous requests: data first, then fetch.
    if_req_i = 1; if_addr_i = 32'h140;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h2000;
    step();
    checkOutput("t3_dm_first", mem_addr_o, 32'h2000);
    mem_ack_i = 1; mem_rdata_i = 32'hA5A5A5A5;
    step();
    checkOutput("t3_dm_ack", {30'b0, if_ack_o, dm_ack_o}, 32'h1);
    checkOutput("t3_dm_rdata", dm_rdata_o, 32'hA5A5A5A5);
    dm_req_i = 0; mem_ack_i = 0;
    step();
    checkOutput("t3_gap", 32'(mem_req_o), 32'h0);
    step();
    checkOutput("t3_if_next", mem_addr_o, 32'h140);
    mem_ack_i = 1; mem_rdata_i = 32'h5A5A5A5A;
    step();
    checkOutput("t3_if_ack", {30'b0, if_ack_o, dm_ack_o}, 32'h2);
    if_req_i = 0; mem_ack_i = 0;
    step();

    // Fairness: both ports keep requesting; data writes mark data grants on mem_we_o.
    if_req_i = 1; if_addr_i = 32'h200;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h3000; dm_wdata_i = 32'h1;
    order = '0; grants = 0; prevReq = 0; memWait = 0;
    for (int i = 0; i < 120 && (if_req_i || dm_req_i || mem_req_o); i++) begin
      step();
      if (mem_req_o && !prevReq && grants < 6) begin
        order[grants] = mem_we_o;
        grants++;
      end
      prevReq = mem_req_o;
      applyStimulus(2, 1'b0);
      if (if_ack_o) begin if_req_i = (grants < 6); if_addr_i = if_addr_i + 4; end
      if (dm_ack_o) begin dm_req_i = (grants < 6); dm_addr_i = dm_addr_i + 4; end
    end
    checkOutput("t4_grant_count", 32'(grants), 32'd6);
    checkOutput("t4_order", 32'(order), 32'h2F);
    checkOutput("t4_drained", {30'b0, if_req_i, dm_req_i}, 32'h0);
    mem_ack_i = 0;
    step(); step();

    // Reset in the middle of a data read.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h3300;
    step();
    checkOutput("t5_serving", 32'(mem_req_o), 32'h1);
    rst_i = 1;
    step();
    checkOutput("t5_req_dropped", 32'(mem_req_o), 32'h0);
    checkOutput("t5_acks", {30'b0, if_ack_o, dm_ack_o}, 32'h0);
    rst_i = 0; dm_req_i = 0; mem_ack_i = 1;
    step();
    checkOutput("t5_late_ack", {30'b0, if_ack_o, dm_ack_o}, 32'h0);
    mem_ack_i = 0;
    step();
    checkOutput("t5_after", {29'b0, mem_req_o, if_ack_o, dm_ack_o}, 32'h0);

    // Spurious acks with no requests pending.
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = ~mem_ack_i;
      step();
      checkOutput("t6_quiet", {29'b0, mem_req_o, if_ack_o, dm_ack_o}, 32'h0);
    end
    mem_ack_i = 0;

    // Randomized traffic with occasional resets.
    memWait = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(399, 0) == 0);
      step();
      applyStimulus(4, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
